// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: byte-beat instruction fetch, op/funct decode, per-state datapath strobes.
// Optional feature: define MIPS_ADDI_EN to add the addi execute/writeback states.
module mips_mc_controller #(
    parameter int FETCH_BEATS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic [3:0] irwrite,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucont,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] LBRD    = 4'd3;
    localparam logic [3:0] LBWR    = 4'd4;
    localparam logic [3:0] SBWR    = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWR = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] JEX     = 4'd9;
`ifdef MIPS_ADDI_EN
    localparam logic [3:0] ADDIEX  = 4'd10;
    localparam logic [3:0] ADDIWR  = 4'd11;
`endif

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] LAST_BEAT = 2'(FETCH_BEATS - 1);

    logic [3:0] state_r;
    logic [3:0] state_next_s;
    logic [1:0] beat_r;
    logic [1:0] beat_next_s;

    logic       memread_s;
    logic       memwrite_s;
    logic [3:0] irwrite_s;
    logic       iord_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [2:0] alucont_s;
    logic [1:0] pcsource_s;
    logic       pcen_s;
    logic       regwrite_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic       illegal_s;

    // IR byte lanes written on a given fetch beat, depending on datapath width
    function automatic logic [3:0] fetch_lanes(input logic [1:0] beat);
        logic [3:0] lanes;
        case (FETCH_BEATS)
            1:       lanes = 4'b1111;
            2:       lanes = beat[0] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b0001 << beat;
        endcase
        return lanes;
    endfunction

    // ALU operation for R-type instructions; unknown functs fall back to ADD
    function automatic logic [2:0] rtype_alucont(input logic [5:0] fn);
        logic [2:0] ac;
        case (fn)
            6'b100000: ac = 3'b010;
            6'b100010: ac = 3'b110;
            6'b100100: ac = 3'b000;
            6'b100101: ac = 3'b001;
            6'b101010: ac = 3'b111;
            default:   ac = 3'b010;
        endcase
        return ac;
    endfunction

    function automatic logic op_supported(input logic [5:0] opc);
        logic ok;
        case (opc)
            OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MIPS_ADDI_EN
            OP_ADDI: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State and fetch-beat registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            beat_r  <= 2'b00;
        end else begin
            state_r <= state_next_s;
            beat_r  <= beat_next_s;
        end
    end

    // Next-state logic; unreachable encodings recover to FETCH
    always_comb begin
        state_next_s = FETCH;
        beat_next_s  = 2'b00;
        case (state_r)
            FETCH: begin
                if (beat_r == LAST_BEAT) begin
                    state_next_s = DECODE;
                    beat_next_s  = 2'b00;
                end else begin
                    state_next_s = FETCH;
                    beat_next_s  = beat_r + 2'b01;
                end
            end
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_next_s = MEMADR;
                    OP_RTYPE:     state_next_s = RTYPEEX;
                    OP_BEQ:       state_next_s = BEQEX;
                    OP_J:         state_next_s = JEX;
`ifdef MIPS_ADDI_EN
                    OP_ADDI:      state_next_s = ADDIEX;
`endif
                    default:      state_next_s = FETCH;
                endcase
            end
            MEMADR: begin
                case (op)
                    OP_LB:   state_next_s = LBRD;
                    OP_SB:   state_next_s = SBWR;
                    default: state_next_s = FETCH;
                endcase
            end
            LBRD:    state_next_s = LBWR;
            RTYPEEX: state_next_s = RTYPEWR;
`ifdef MIPS_ADDI_EN
            ADDIEX:  state_next_s = ADDIWR;
`endif
            default: state_next_s = FETCH;
        endcase
    end

    // Moore output decode; pcen in BEQEX and alucont in RTYPEEX also look at inputs
    always_comb begin
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 4'b0000;
        iord_s     = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        alucont_s  = 3'b000;
        pcsource_s = 2'b00;
        pcen_s     = 1'b0;
        regwrite_s = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        illegal_s  = 1'b0;
        case (state_r)
            FETCH: begin
                memread_s = 1'b1;
                irwrite_s = fetch_lanes(beat_r);
                alusrcb_s = 2'b01;
                alucont_s = 3'b010;
                pcen_s    = 1'b1;
            end
            DECODE: begin
                alusrcb_s = 2'b11;
                alucont_s = 3'b010;
                illegal_s = ~op_supported(op);
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                alucont_s = 3'b010;
            end
            LBRD: begin
                memread_s = 1'b1;
                iord_s    = 1'b1;
            end
            LBWR: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
            end
            SBWR: begin
                memwrite_s = 1'b1;
                iord_s     = 1'b1;
            end
            RTYPEEX: begin
                alusrca_s = 1'b1;
                alucont_s = rtype_alucont(funct);
            end
            RTYPEWR: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
            end
            BEQEX: begin
                alusrca_s  = 1'b1;
                alucont_s  = 3'b110;
                pcsource_s = 2'b01;
                pcen_s     = zero;
            end
            JEX: begin
                pcsource_s = 2'b10;
                pcen_s     = 1'b1;
            end
`ifdef MIPS_ADDI_EN
            ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                alucont_s = 3'b010;
            end
            ADDIWR: begin
                regwrite_s = 1'b1;
            end
`endif
            default: begin
                memread_s = 1'b0;
            end
        endcase
    end

    // Reset masks every strobe so an aborted instruction cannot write anything
    assign memread  = reset ? 1'b0    : memread_s;
    assign memwrite = reset ? 1'b0    : memwrite_s;
    assign irwrite  = reset ? 4'b0000 : irwrite_s;
    assign iord     = reset ? 1'b0    : iord_s;
    assign alusrca  = reset ? 1'b0    : alusrca_s;
    assign alusrcb  = reset ? 2'b00   : alusrcb_s;
    assign alucont  = reset ? 3'b000  : alucont_s;
    assign pcsource = reset ? 2'b00   : pcsource_s;
    assign pcen     = reset ? 1'b0    : pcen_s;
    assign regwrite = reset ? 1'b0    : regwrite_s;
    assign regdst   = reset ? 1'b0    : regdst_s;
    assign memtoreg = reset ? 1'b0    : memtoreg_s;
    assign illegal  = reset ? 1'b0    : illegal_s;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: per-cycle expected control words queued with their inputs.
module tb_mips_mc_controller;

    localparam int FB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b000000;
    logic [5:0] funct = 6'b000000;
    logic       zero = 1'b0;
    logic       memread, memwrite, iord, alusrca, pcen, regwrite, regdst, memtoreg, illegal;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucont;
    logic [19:0] obs;

    logic [19:0] exp_q[$];
    logic [13:0] in_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    mips_mc_controller #(.FETCH_BEATS(FB)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .iord(iord),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont), .pcsource(pcsource),
        .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .illegal(illegal)
    );

    assign obs = {memread, memwrite, irwrite, iord, alusrca, alusrcb, alucont,
                  pcsource, pcen, regwrite, regdst, memtoreg, illegal};

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, want);
    endtask

    function automatic logic [19:0] mk(input logic mr, input logic mw, input logic [3:0] irw,
                                       input logic io, input logic asa, input logic [1:0] asb,
                                       input logic [2:0] ac, input logic [1:0] ps, input logic pe,
                                       input logic rw, input logic rd, input logic mtr,
                                       input logic ill);
        return {mr, mw, irw, io, asa, asb, ac, ps, pe, rw, rd, mtr, ill};
    endfunction

    function automatic logic [2:0] exp_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic exp_legal(input logic [5:0] o);
        case (o)
            6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010: return 1'b1;
`ifdef MIPS_ADDI_EN
            6'b001000: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input string tag, input logic [19:0] v, input logic rst,
                        input logic [5:0] o, input logic [5:0] f, input logic z);
        exp_q.push_back(v);
        in_q.push_back({rst, o, f, z});
        tag_q.push_back(tag);
    endtask

    task automatic push_fetch(input string nm, input int nbeats);
        logic [3:0] lanes [4];
        lanes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int b = 0; b < nbeats; b++)
            push($sformatf("%s_fetch%0d", nm, b),
                 mk(1'b1, 1'b0, lanes[b], 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0),
                 1'b0, 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0)), 1'($urandom_range(1, 0)));
    endtask

    task automatic push_reset(input string nm, input int n);
        for (int i = 0; i < n; i++)
            push($sformatf("%s_rst%0d", nm, i), 20'd0, 1'b1, 6'($urandom_range(63, 0)),
                 6'b000000, 1'b0);
    endtask

    // Apply each queued input set, then compare the output word away from the clock edge
    task automatic drain();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            {reset, op, funct, zero} = in_q.pop_front();
            #2;
            check_val(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input bit abort_last);
        push_fetch(nm, FB);
        push({nm, "_decode"}, mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 1'b0,
             1'b0, 1'b0, 1'b0, ~exp_legal(o)), 1'b0, o, f, z);
        case (o)
            6'b100000: begin
                push({nm, "_memadr"}, mk(0, 0, 4'b0000, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0, 0, 0), 1'b0, o, f, z);
                push({nm, "_lbrd"}, mk(1, 0, 4'b0000, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0), 1'b0, o, f, z);
                push({nm, "_lbwr"}, mk(0, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0, 1, 0), 1'b0, o, f, z);
            end
            6'b101000: begin
                push({nm, "_memadr"}, mk(0, 0, 4'b0000, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0, 0, 0), 1'b0, o, f, z);
                push({nm, "_sbwr"}, mk(0, 1, 4'b0000, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0), 1'b0, o, f, z);
            end
            6'b000000: begin
                push({nm, "_rex"}, mk(0, 0, 4'b0000, 0, 1, 2'b00, exp_alu(f), 2'b00, 0, 0, 0, 0, 0), 1'b0, o, f, z);
                push({nm, "_rwr"}, mk(0, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 1, 0, 0), 1'b0, o, f, z);
            end
            6'b000100:
                push({nm, "_beqex"}, mk(0, 0, 4'b0000, 0, 1, 2'b00, 3'b110, 2'b01, z, 0, 0, 0, 0), 1'b0, o, f, z);
            6'b000010:
                push({nm, "_jex"}, mk(0, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0, 0, 0, 0), 1'b0, o, f, z);
`ifdef MIPS_ADDI_EN
            6'b001000: begin
                push({nm, "_addiex"}, mk(0, 0, 4'b0000, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0, 0, 0), 1'b0, o, f, z);
                push({nm, "_addiwr"}, mk(0, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0, 0, 0), 1'b0, o, f, z);
            end
`endif
            default: ;
        endcase
        if (abort_last) begin
            void'(exp_q.pop_back());
            void'(in_q.pop_back());
            void'(tag_q.pop_back());
            push_reset({nm, "_abort"}, 2);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        push_reset("por", 2);
        push_fetch("pre", 2);
        push_reset("midfetch", 3);
        drain();

        instr("slt",   6'b000000, 6'b101010, 1'b0, 1'b0);
        instr("lb",    6'b100000, 6'b000000, 1'b0, 1'b0);
        instr("sb",    6'b101000, 6'b000000, 1'b0, 1'b0);
        instr("beq1",  6'b000100, 6'b000000, 1'b1, 1'b0);
        instr("beq0",  6'b000100, 6'b000000, 1'b0, 1'b0);
        instr("j",     6'b000010, 6'b000000, 1'b0, 1'b0);
        instr("ill",   6'b111111, 6'b000000, 1'b0, 1'b0);
        instr("addi",  6'b001000, 6'b000000, 1'b0, 1'b0);
        instr("add",   6'b000000, 6'b100000, 1'b0, 1'b0);
        instr("sub",   6'b000000, 6'b100010, 1'b0, 1'b0);
        instr("and",   6'b000000, 6'b100100, 1'b0, 1'b0);
        instr("or",    6'b000000, 6'b100101, 1'b0, 1'b0);
        instr("rdflt", 6'b000000, 6'b100111, 1'b0, 1'b0);
        instr("lbabt", 6'b100000, 6'b000000, 1'b0, 1'b1);
        instr("sbabt", 6'b101000, 6'b000000, 1'b0, 1'b1);
        push_fetch("final", 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
